button_conditioner: RTL and testbench

- Multi-channel input conditioner for the alarm-clock front-panel buttons and switches.
- Per channel, in order:
  - parametrised flip-flop synchroniser chain;
  - counter-based debouncer;
  - registered level and inverted-level outputs;
  - single-cycle rise and fall pulses.
- Sits between the raw board pins and the time/alarm-setting control FSM. Replaces ad-hoc single-flop sampling of button inputs.

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, counter debouncer, level and
// edge-pulse outputs for front-panel buttons and switches.
// Optional auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined;
// otherwise btn_repeat is tied low and no repeat logic exists.
module button_conditioner #(
    parameter int unsigned CHANNELS        = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_nlevel,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_repeat
);

    // Counter holds 0..DEBOUNCE_CYCLES-1 and never wraps.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W  = $clog2(RPT_MAX + 1);
    localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } phase_e;
`endif

    // Inverted level is a pure function of the registered level.
    assign btn_nlevel = ~btn_level;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   level_q;
        logic                   level_d;
        logic                   rise_q;
        logic                   rise_d;
        logic                   fall_q;
        logic                   fall_d;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce decision: count consecutive disagreeing cycles, flip on the last.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Synchroniser chain and debounce state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;

`ifdef BTN_AUTOREPEAT_EN
        phase_e            phase_q;
        phase_e            phase_d;
        logic [RCNT_W-1:0] rcnt_q;
        logic [RCNT_W-1:0] rcnt_d;
        logic              rep_q;
        logic              rep_d;

        // Repeat FSM: keyed on the next level so a fall edge never emits a pulse.
        always_comb begin
            phase_d = phase_q;
            rcnt_d  = rcnt_q;
            rep_d   = 1'b0;
            if (!level_d) begin
                phase_d = PH_DELAY;
                rcnt_d  = '0;
            end else if (rise_d) begin
                rep_d   = 1'b1;
                phase_d = PH_DELAY;
                rcnt_d  = '0;
            end else begin
                case (phase_q)
                    PH_DELAY: begin
                        if (rcnt_q == RD_LAST) begin
                            rep_d   = 1'b1;
                            phase_d = PH_PERIOD;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    PH_PERIOD: begin
                        if (rcnt_q == RP_LAST) begin
                            rep_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        phase_d = PH_DELAY;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // Repeat state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= PH_DELAY;
                rcnt_q  <= '0;
                rep_q   <= 1'b0;
            end else begin
                phase_q <= phase_d;
                rcnt_q  <= rcnt_d;
                rep_q   <= rep_d;
            end
        end

        assign btn_repeat[i] = rep_q;
`endif
    end

`ifndef BTN_AUTOREPEAT_EN
    // Repeat timing parameters only fold into a constant here; the port stays low.
    localparam bit REPEAT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
    assign btn_repeat = {CHANNELS{1'b0}} & {CHANNELS{REPEAT_CFG_OK}};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a per-cycle expected-output
// scoreboard; a separate monitor pops and compares after every clock edge.
module tb_button_conditioner;

    localparam int unsigned CH = 2;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_nlevel;
    logic [CH-1:0] btn_rise;
    logic [CH-1:0] btn_fall;
    logic [CH-1:0] btn_repeat;

    button_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_nlevel (btn_nlevel),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] lev;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] rep;
        string         nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input string sig, input logic [CH-1:0] act, input logic [CH-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s.%s: got %b, want %b (t=%0t)", nm, sig, act, want, $time);
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [CH-1:0] raw, input logic [CH-1:0] lev,
                        input logic [CH-1:0] rise, input logic [CH-1:0] fall,
                        input logic [CH-1:0] rep, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        btn_raw = raw;
        e.lev   = lev;
        e.rise  = rise;
        e.fall  = fall;
        e.rep   = REP_EN ? rep : 2'b00;
        e.nm    = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every output after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "level",  btn_level,  e.lev);
                chk(e.nm, "nlevel", btn_nlevel, ~e.lev);
                chk(e.nm, "rise",   btn_rise,   e.rise);
                chk(e.nm, "fall",   btn_fall,   e.fall);
                chk(e.nm, "repeat", btn_repeat, e.rep);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        btn_raw = 2'b00;

        // Reset with inputs high, then release: rise on both at edge 6, fall at 12.
        repeat (3) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "rst_hold");
        for (int k = 1; k <= 14; k++)
            step(1'b0, (k <= 6) ? 2'b11 : 2'b00,
                 (k >= 6 && k < 12) ? 2'b11 : 2'b00,
                 (k == 6) ? 2'b11 : 2'b00,
                 (k == 12) ? 2'b11 : 2'b00,
                 (k == 6) ? 2'b11 : 2'b00, "rst_release");

        // Ch0 held 20 cycles: rise at 6, fall at 26, repeats at 6,16,19,22,25.
        for (int k = 1; k <= 32; k++)
            step(1'b0, (k <= 20) ? 2'b01 : 2'b00,
                 (k >= 6 && k < 26) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00,
                 (k == 26) ? 2'b01 : 2'b00,
                 (k inside {6, 16, 19, 22, 25}) ? 2'b01 : 2'b00, "press_hold");

        // Ch1 short pulse of 3 cycles, then 2-cycle toggling: always rejected.
        for (int k = 1; k <= 10; k++)
            step(1'b0, (k <= 3) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3");
        for (int k = 1; k <= 40; k++)
            step(1'b0, (((k / 2) % 2) == 1) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "toggle2");
        for (int k = 1; k <= 6; k++)
            step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "settle");

        // Auto-repeat then reset at rise+12 with button still held.
        for (int k = 1; k <= 17; k++)
            step(1'b0, 2'b01,
                 (k >= 6) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00,
                 2'b00,
                 (k == 6 || k == 16) ? 2'b01 : 2'b00, "repeat_run");
        for (int k = 18; k <= 20; k++)
            step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "repeat_rst");
        for (int k = 21; k <= 30; k++)
            step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "post_rst");

        // Both pressed together, ch1 released after 2 cycles; ch0 fall at 16 has no repeat.
        for (int k = 1; k <= 22; k++)
            step(1'b0, (k <= 2) ? 2'b11 : ((k <= 10) ? 2'b01 : 2'b00),
                 (k >= 6 && k < 16) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00,
                 (k == 16) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00, "dual_press");

        // Let the monitor drain the scoreboard, bounded by a few cycles.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
